// File: rtl/bcd_clock_register.sv
// Time-of-day counter holding six packed BCD digits {ht,ho,mt,mo,st,so}.
// Advances from a prescaled tick stream in 24h or 12h (am/pm) mode; loads are range-checked.
module bcd_clock_register #(
  parameter int TICKS_PER_SEC = 1,
  parameter bit MODE_24H      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        tick,
  input  logic        load,
  input  logic [23:0] ld_time,
  input  logic        ld_pm,
  output logic [23:0] time_out,
  output logic        pm,
  output logic        sec_pulse,
  output logic        day_wrap,
  output logic        load_err
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(TICKS_PER_SEC - 1);

  // 12h mode powers up at 12:00:00 AM.
  localparam logic [3:0] RST_HT = MODE_24H ? 4'd0 : 4'd1;
  localparam logic [3:0] RST_HO = MODE_24H ? 4'd0 : 4'd2;

  logic [3:0]    ht_q, ho_q, mt_q, mo_q, st_q, so_q;
  logic [3:0]    ht_d, ho_d, mt_d, mo_d, st_d, so_d;
  logic          pm_q, pm_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          sec_pulse_q, sec_pulse_d;
  logic          day_wrap_q, day_wrap_d;
  logic          load_err_q, load_err_d;

  logic [3:0]    ld_ht, ld_ho, ld_mt, ld_mo, ld_st, ld_so;
  logic          digits_ok;
  logic          hour_ok;
  logic          ld_valid;
  logic          sec_adv;
  logic          min_carry;
  logic          hour_carry;

  assign ld_ht = ld_time[23:20];
  assign ld_ho = ld_time[19:16];
  assign ld_mt = ld_time[15:12];
  assign ld_mo = ld_time[11:8];
  assign ld_st = ld_time[7:4];
  assign ld_so = ld_time[3:0];

  // Load range check.
  always_comb begin
    digits_ok = (ld_ht <= 4'd9) && (ld_ho <= 4'd9) &&
                (ld_mt <= 4'd5) && (ld_mo <= 4'd9) &&
                (ld_st <= 4'd5) && (ld_so <= 4'd9);
    if (MODE_24H) begin
      hour_ok = (ld_ht < 4'd2) || ((ld_ht == 4'd2) && (ld_ho <= 4'd3));
    end else begin
      hour_ok = ((ld_ht == 4'd0) && (ld_ho != 4'd0)) ||
                ((ld_ht == 4'd1) && (ld_ho <= 4'd2));
    end
    ld_valid = digits_ok && hour_ok;
  end

  assign sec_adv = en && tick && (presc_q == PS_MAX);

  // Seconds and minutes ripple; hour_carry fires when mm:ss goes 59:59 -> 00:00.
  always_comb begin
    so_d       = so_q;
    st_d       = st_q;
    mo_d       = mo_q;
    mt_d       = mt_q;
    min_carry  = 1'b0;
    hour_carry = 1'b0;
    if (so_q != 4'd9) begin
      so_d = so_q + 4'd1;
    end else begin
      so_d = 4'd0;
      if (st_q != 4'd5) begin
        st_d = st_q + 4'd1;
      end else begin
        st_d      = 4'd0;
        min_carry = 1'b1;
      end
    end
    if (min_carry) begin
      if (mo_q != 4'd9) begin
        mo_d = mo_q + 4'd1;
      end else begin
        mo_d = 4'd0;
        if (mt_q != 4'd5) begin
          mt_d = mt_q + 4'd1;
        end else begin
          mt_d       = 4'd0;
          hour_carry = 1'b1;
        end
      end
    end
  end

  // Next-state selection: load beats tick, and a load of either kind consumes the cycle.
  always_comb begin
    ht_d        = ht_q;
    ho_d        = ho_q;
    pm_d        = pm_q;
    presc_d     = presc_q;
    sec_pulse_d = 1'b0;
    day_wrap_d  = 1'b0;
    load_err_d  = 1'b0;
    if (load) begin
      if (!ld_valid) begin
        load_err_d = 1'b1;
      end else begin
        ht_d    = ld_ht;
        ho_d    = ld_ho;
        pm_d    = MODE_24H ? 1'b0 : ld_pm;
        presc_d = '0;
      end
    end else if (en && tick) begin
      if (!sec_adv) begin
        presc_d = presc_q + 1'b1;
      end else begin
        presc_d     = '0;
        sec_pulse_d = 1'b1;
        if (hour_carry) begin
          if (MODE_24H) begin
            if ((ht_q == 4'd2) && (ho_q == 4'd3)) begin
              ht_d       = 4'd0;
              ho_d       = 4'd0;
              day_wrap_d = 1'b1;
            end else if (ho_q == 4'd9) begin
              ht_d = ht_q + 4'd1;
              ho_d = 4'd0;
            end else begin
              ho_d = ho_q + 4'd1;
            end
          end else begin
            // 11 -> 12 flips am/pm; leaving 11 PM is the midnight roll-over.
            if ((ht_q == 4'd1) && (ho_q == 4'd1)) begin
              ht_d       = 4'd1;
              ho_d       = 4'd2;
              pm_d       = ~pm_q;
              day_wrap_d = pm_q;
            end else if ((ht_q == 4'd1) && (ho_q == 4'd2)) begin
              ht_d = 4'd0;
              ho_d = 4'd1;
            end else if (ho_q == 4'd9) begin
              ht_d = ht_q + 4'd1;
              ho_d = 4'd0;
            end else begin
              ho_d = ho_q + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ht_q        <= RST_HT;
      ho_q        <= RST_HO;
      mt_q        <= 4'd0;
      mo_q        <= 4'd0;
      st_q        <= 4'd0;
      so_q        <= 4'd0;
      pm_q        <= 1'b0;
      presc_q     <= '0;
      sec_pulse_q <= 1'b0;
      day_wrap_q  <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      ht_q        <= ht_d;
      ho_q        <= ho_d;
      if (load) begin
        if (ld_valid) begin
          mt_q <= ld_mt;
          mo_q <= ld_mo;
          st_q <= ld_st;
          so_q <= ld_so;
        end
      end else if (sec_adv) begin
        mt_q <= mt_d;
        mo_q <= mo_d;
        st_q <= st_d;
        so_q <= so_d;
      end
      pm_q        <= pm_d;
      presc_q     <= presc_d;
      sec_pulse_q <= sec_pulse_d;
      day_wrap_q  <= day_wrap_d;
      load_err_q  <= load_err_d;
    end
  end

  assign time_out  = {ht_q, ho_q, mt_q, mo_q, st_q, so_q};
  assign pm        = MODE_24H ? 1'b0 : pm_q;
  assign sec_pulse = sec_pulse_q;
  assign day_wrap  = day_wrap_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_bcd_clock_register.sv
// Bench for bcd_clock_register: three instances (24h/1 tick, 12h/1 tick, 24h/4 ticks) share
// one stimulus stream and are checked every cycle against a seconds-of-day reference model.
module tb_bcd_clock_register;

  localparam int N = 3;

  logic        clk;
  logic        reset;
  logic        en;
  logic        tick;
  logic        load;
  logic [23:0] ld_time;
  logic        ld_pm;

  logic [23:0] time_out_a [N];
  logic        pm_a       [N];
  logic        sec_pulse_a[N];
  logic        day_wrap_a [N];
  logic        load_err_a [N];

  int tests_run;
  int tests_failed;

  // Model state: seconds since midnight and prescaler count per instance.
  int secs [N];
  int presc[N];
  // Expected {time_out, pm, sec_pulse, day_wrap, load_err}, N entries pushed per cycle.
  logic [27:0] exp_q[$];

  bcd_clock_register #(.TICKS_PER_SEC(1), .MODE_24H(1'b1)) dut24 (
    .clk(clk), .reset(reset), .en(en), .tick(tick), .load(load),
    .ld_time(ld_time), .ld_pm(ld_pm), .time_out(time_out_a[0]), .pm(pm_a[0]),
    .sec_pulse(sec_pulse_a[0]), .day_wrap(day_wrap_a[0]), .load_err(load_err_a[0])
  );

  bcd_clock_register #(.TICKS_PER_SEC(1), .MODE_24H(1'b0)) dut12 (
    .clk(clk), .reset(reset), .en(en), .tick(tick), .load(load),
    .ld_time(ld_time), .ld_pm(ld_pm), .time_out(time_out_a[1]), .pm(pm_a[1]),
    .sec_pulse(sec_pulse_a[1]), .day_wrap(day_wrap_a[1]), .load_err(load_err_a[1])
  );

  bcd_clock_register #(.TICKS_PER_SEC(4), .MODE_24H(1'b1)) dut4 (
    .clk(clk), .reset(reset), .en(en), .tick(tick), .load(load),
    .ld_time(ld_time), .ld_pm(ld_pm), .time_out(time_out_a[2]), .pm(pm_a[2]),
    .sec_pulse(sec_pulse_a[2]), .day_wrap(day_wrap_a[2]), .load_err(load_err_a[2])
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int tps_of(int i);
    return (i == 2) ? 4 : 1;
  endfunction

  function automatic bit m24_of(int i);
    return (i != 1);
  endfunction

  function automatic bit load_ok(logic [23:0] t, bit m24);
    int ht, ho, mt, mo, st, so, h;
    ht = int'(t[23:20]); ho = int'(t[19:16]);
    mt = int'(t[15:12]); mo = int'(t[11:8]);
    st = int'(t[7:4]);   so = int'(t[3:0]);
    if (ht > 9 || ho > 9 || mt > 5 || mo > 9 || st > 5 || so > 9) return 1'b0;
    h = ht * 10 + ho;
    if (m24) return (h <= 23);
    return (h >= 1 && h <= 12);
  endfunction

  function automatic int to_secs(logic [23:0] t, bit p, bit m24);
    int h, m, s;
    h = int'(t[23:20]) * 10 + int'(t[19:16]);
    m = int'(t[15:12]) * 10 + int'(t[11:8]);
    s = int'(t[7:4]) * 10 + int'(t[3:0]);
    if (!m24) h = (h % 12) + (p ? 12 : 0);
    return h * 3600 + m * 60 + s;
  endfunction

  function automatic logic [23:0] disp_time(int sec_of_day, bit m24);
    int h, m, s;
    h = sec_of_day / 3600;
    m = (sec_of_day / 60) % 60;
    s = sec_of_day % 60;
    if (!m24) h = ((h % 12) == 0) ? 12 : (h % 12);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [23:0] mk(int h, int m, int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      logic s, w, e, p;
      s = 1'b0; w = 1'b0; e = 1'b0;
      if (reset) begin
        secs[i]  = 0;
        presc[i] = 0;
      end else if (load) begin
        if (load_ok(ld_time, m24_of(i))) begin
          secs[i]  = to_secs(ld_time, ld_pm, m24_of(i));
          presc[i] = 0;
        end else begin
          e = 1'b1;
        end
      end else if (en && tick) begin
        presc[i] = presc[i] + 1;
        if (presc[i] == tps_of(i)) begin
          presc[i] = 0;
          secs[i]  = (secs[i] + 1) % 86400;
          s = 1'b1;
          w = (secs[i] == 0);
        end
      end
      p = !m24_of(i) && (secs[i] >= 43200);
      exp_q.push_back({disp_time(secs[i], m24_of(i)), p, s, w, e});
    end
  endtask

  // Scoreboard comparisons
  task automatic chk(string tag, logic [23:0] obs, logic [23:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    logic [27:0] ex;
    for (int i = 0; i < N; i++) begin
      ex = exp_q.pop_front();
      chk($sformatf("time_out[%0d]", i), time_out_a[i], ex[27:4]);
      chk1($sformatf("pm[%0d]", i), pm_a[i], ex[3]);
      chk1($sformatf("sec_pulse[%0d]", i), sec_pulse_a[i], ex[2]);
      chk1($sformatf("day_wrap[%0d]", i), day_wrap_a[i], ex[1]);
      chk1($sformatf("load_err[%0d]", i), load_err_a[i], ex[0]);
    end
  endtask

  // Driver: inputs are applied 1 time unit after the edge, outputs checked there too.
  task automatic drive(logic r, logic e, logic t, logic l, logic [23:0] lt, logic p);
    reset = r; en = e; tick = t; load = l; ld_time = lt; ld_pm = p;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int n4;
    int r;
    logic [23:0] lt;
    logic [23:0] bad_loads[4];
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < N; i++) begin
      secs[i]  = 0;
      presc[i] = 0;
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
    #1;

    // Reset values in both modes.
    step();
    step();
    chk("rst_time24", time_out_a[0], 24'h000000);
    chk("rst_time12", time_out_a[1], 24'h120000);
    chk1("rst_pm12", pm_a[1], 1'b0);

    // Eight back-to-back ticks: divide-by-4 instance advances twice.
    n4 = 0;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step();
      n4 += int'(sec_pulse_a[2]);
    end
    chk("div4_pulses", 24'(n4), 24'd2);
    chk("div4_time", time_out_a[2], 24'h000002);
    chk("div1_time", time_out_a[0], 24'h000008);

    // Ticks with en low are ignored and the prescaler holds.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 1'b0);
    for (int k = 0; k < 3; k++) step();
    chk("en_low_hold", time_out_a[2], 24'h000002);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
    for (int k = 0; k < 3; k++) step();
    chk("presc_held_3", time_out_a[2], 24'h000002);
    step();
    chk("presc_held_4", time_out_a[2], 24'h000003);

    // 24h midnight roll-over (hour 23 is rejected by the 12h instance).
    drive(1'b0, 1'b1, 1'b0, 1'b1, 24'h235958, 1'b0);
    step();
    chk1("ld23_err12", load_err_a[1], 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
    step();
    chk("t235959", time_out_a[0], 24'h235959);
    step();
    chk("t000000", time_out_a[0], 24'h000000);
    chk1("wrap24", day_wrap_a[0], 1'b1);
    chk1("sec24", sec_pulse_a[0], 1'b1);

    // 12h transitions: 11 AM -> 12 PM, 11 PM -> 12 AM, 12 -> 01.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 24'h115959, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
    step();
    chk("t12_noon", time_out_a[1], 24'h120000);
    chk1("pm_noon", pm_a[1], 1'b1);
    chk1("wrap_noon", day_wrap_a[1], 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 24'h115959, 1'b1);
    step();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
    step();
    chk("t12_mid", time_out_a[1], 24'h120000);
    chk1("pm_mid", pm_a[1], 1'b0);
    chk1("wrap12", day_wrap_a[1], 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 24'h125959, 1'b1);
    step();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
    step();
    chk("t12_one", time_out_a[1], 24'h010000);
    chk1("pm_one", pm_a[1], 1'b1);

    // Rejected loads leave time and prescaler alone (divide-by-4 is mid-count).
    drive(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
    step();
    step();
    bad_loads[0] = 24'h246000;
    bad_loads[1] = 24'h0A0000;
    bad_loads[2] = 24'h006000;
    bad_loads[3] = 24'h000000;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, bad_loads[k], 1'b0);
      step();
      chk1($sformatf("bad_err12_%0d", k), load_err_a[1], 1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 1'b0);
      step();
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
    step();
    step();

    // Load with coincident tick: load wins, no seconds pulse.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 24'h101010, 1'b0);
    step();
    chk("ld_tick", time_out_a[0], 24'h101010);
    chk1("ld_tick_sec", sec_pulse_a[0], 1'b0);

    // Reset mid-count.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 24'h000530, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
    for (int k = 0; k < 7; k++) step();
    chk("t000537", time_out_a[0], 24'h000537);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 24'h101010, 1'b0);
    step();
    chk("rst_mid", time_out_a[0], 24'h000000);

    // Randomized traffic with loads biased towards hour carries.
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 3));
      case (r)
        0: lt = 24'($urandom);
        1: lt = mk(int'($urandom_range(0, 23)), 59, int'($urandom_range(50, 59)));
        2: lt = mk(int'($urandom_range(1, 12)), 59, int'($urandom_range(55, 59)));
        default: lt = mk(int'($urandom_range(0, 25)), int'($urandom_range(0, 61)),
                         int'($urandom_range(0, 61)));
      endcase
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0),
            lt,
            1'($urandom_range(0, 1)));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
